// File: rtl/rsa_mexp_seq.sv
// rsa_mexp_seq: operation sequencer for Montgomery modular exponentiation
// X = M^E mod N, driving a shared external Montgomery multiplier.
//
// Ports:
//   clk, rstb       clock, async active-low reset
//   ena             clock enable (state frozen, strobes masked when low)
//   start, stop     begin run (IDLE only) / abort to IDLE (highest priority)
//   exponent        E, latched when start is accepted
//   mm_start        one-cycle multiplier launch
//   mm_done         multiplier result valid (sampled in WAIT only)
//   mm_sel_a        A operand: 0=X, 1=M, 2=one, 3=message
//   mm_sel_b        B operand: 0=X, 1=M, 2=one, 3=R^2
//   wr_x, wr_m      write multiplier result into X / M register
//   busy            not idle
//   bit_idx         exponent bit being processed
//   eoc             one-cycle end-of-conversion pulse
module rsa_mexp_seq #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] exponent,
  output logic             mm_start,
  input  logic             mm_done,
  output logic [1:0]       mm_sel_a,
  output logic [1:0]       mm_sel_b,
  output logic             wr_x,
  output logic             wr_m,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx,
  output logic             eoc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_PRE_M,
    OP_PRE_X,
    OP_SQR,
    OP_MUL,
    OP_POST
  } op_t;

  state_t           r_state;
  state_t           w_state_nx;
  op_t              r_op;
  op_t              w_op_nx;
  logic [IDX_W-1:0] r_bit_idx;
  logic [IDX_W-1:0] w_idx_nx;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] w_exp_nx;
  logic             w_bit;
  logic             w_last;
  logic             w_fire;

  assign w_bit   = r_exp[r_bit_idx];
  assign w_last  = (r_bit_idx == '0);
  // Pulses and strobes only fire in an enabled, non-aborted cycle.
  assign w_fire  = ena & ~stop;
  assign bit_idx = r_bit_idx;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_op      <= OP_PRE_M;
      r_bit_idx <= '0;
      r_exp     <= '0;
    end else if (ena) begin
      r_state   <= w_state_nx;
      r_op      <= w_op_nx;
      r_bit_idx <= w_idx_nx;
      r_exp     <= w_exp_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_idx_nx   = r_bit_idx;
    w_exp_nx   = r_exp;
    if (stop) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_exp_nx   = exponent;
            w_op_nx    = OP_PRE_M;
            w_state_nx = S_ISSUE;
          end
        end
        S_ISSUE: w_state_nx = S_WAIT;
        S_WAIT: begin
          if (mm_done) begin
            w_state_nx = S_ISSUE;
            unique case (r_op)
              OP_PRE_M: w_op_nx = OP_PRE_X;
              OP_PRE_X: begin
                w_op_nx  = OP_SQR;
                w_idx_nx = IDX_W'(WIDTH - 1);
              end
              OP_SQR: begin
                // Leading zeros still get squared; only set bits multiply.
                if (w_bit) begin
                  w_op_nx = OP_MUL;
                end else if (w_last) begin
                  w_op_nx = OP_POST;
                end else begin
                  w_idx_nx = r_bit_idx - IDX_W'(1);
                end
              end
              OP_MUL: begin
                if (w_last) begin
                  w_op_nx = OP_POST;
                end else begin
                  w_op_nx  = OP_SQR;
                  w_idx_nx = r_bit_idx - IDX_W'(1);
                end
              end
              OP_POST: w_state_nx = S_DONE;
              default: begin
                w_state_nx = S_IDLE;
                w_op_nx    = OP_PRE_M;
              end
            endcase
          end
        end
        S_DONE:  w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mm_start = 1'b0;
    mm_sel_a = 2'd0;
    mm_sel_b = 2'd0;
    wr_x     = 1'b0;
    wr_m     = 1'b0;
    eoc      = 1'b0;
    busy     = (r_state != S_IDLE);
    if (r_state == S_ISSUE || r_state == S_WAIT) begin
      unique case (r_op)
        OP_PRE_M: begin mm_sel_a = 2'd3; mm_sel_b = 2'd3; end
        OP_PRE_X: begin mm_sel_a = 2'd2; mm_sel_b = 2'd3; end
        OP_SQR:   begin mm_sel_a = 2'd0; mm_sel_b = 2'd0; end
        OP_MUL:   begin mm_sel_a = 2'd0; mm_sel_b = 2'd1; end
        OP_POST:  begin mm_sel_a = 2'd0; mm_sel_b = 2'd2; end
        default: ;
      endcase
    end
    unique case (r_state)
      S_ISSUE: mm_start = w_fire;
      S_WAIT: begin
        if (w_fire && mm_done) begin
          unique case (r_op)
            OP_PRE_M: wr_m = 1'b1;
            OP_PRE_X, OP_SQR, OP_MUL, OP_POST: wr_x = 1'b1;
            default: ;
          endcase
        end
      end
      S_DONE:  eoc = w_fire;
      default: ;
    endcase
  end

endmodule
